// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: arbitrates NCH requester channels onto one external memory
// interface. Fixed (lowest index wins) or round-robin priority. The grant is
// held for a whole transaction; read data is latched and returned with a
// one-cycle one-hot ack pulse.
module hs32_mem_arb #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int RR  = 0,
  parameter int GW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [AW-1:0]     addr,
  output logic              rw,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              valid,
  input  logic              done,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    rw_i,
  input  logic [NCH*AW-1:0] addr_i,
  input  logic [NCH*DW-1:0] dtw_i,
  output logic [DW-1:0]     dtr,
  output logic [NCH-1:0]    ack,
  output logic [GW-1:0]     gnt_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [GW-1:0]    gnt_id_r;
  logic [GW-1:0]    last_r;
  logic             valid_r;
  logic             busy_r;
  logic [NCH-1:0]   ack_r;
  logic [DW-1:0]    dtr_r;

  logic [GW-1:0]    win_s;
  logic             found_s;
  logic [NCH-1:0]   gnt_oh_s;

  // Winner search: fixed mode scans from index 0; round-robin mode scans
  // starting just after the last granted channel, wrapping modulo NCH.
  always_comb begin
    int idx_v;
    idx_v   = 0;
    win_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx_v   = (RR != 0) ? ((int'(last_r) + 1 + i) % NCH) : i;
      win_s   = (req[idx_v] && !found_s) ? GW'(idx_v) : win_s;
      found_s = found_s | req[idx_v];
    end
  end

  // The external side is forwarded from the registered grant index, so the
  // bus only depends on gnt_id and never glitches with other requests.
  assign addr     = addr_i[int'(gnt_id_r)*AW +: AW];
  assign dout     = dtw_i[int'(gnt_id_r)*DW +: DW];
  assign rw       = rw_i[gnt_id_r];
  assign gnt_oh_s = {{(NCH-1){1'b0}}, 1'b1} << gnt_id_r;

  assign valid  = valid_r;
  assign busy   = busy_r;
  assign ack    = ack_r;
  assign dtr    = dtr_r;
  assign gnt_id = gnt_id_r;

  // Arbitration FSM with all outputs registered; reset aborts any transaction
  // in flight without issuing an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      gnt_id_r <= '0;
      last_r   <= GW'(NCH-1);
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      ack_r    <= '0;
      dtr_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_id_r <= win_s;
            last_r   <= (RR != 0) ? win_s : last_r;
            valid_r  <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= GNT;
          end
        end
        GNT: begin
          // Grant is locked here: req changes are ignored until done.
          if (done) begin
            dtr_r   <= din;
            valid_r <= 1'b0;
            ack_r   <= gnt_oh_s;
            state_r <= RESP;
          end
        end
        RESP: begin
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          ack_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Bench for hs32_mem_arb: three instances (NCH=2 fixed, NCH=4 fixed,
// NCH=4 round-robin) share the channel buses, clock, reset and memory side.
// A scoreboard queue holds the expected transactions in grant order.
module tb_hs32_mem_arb;

  logic         clk;
  logic         reset;
  logic [31:0]  din;
  logic         done;
  logic [3:0]   rw_i4;
  logic [127:0] addr_i4;
  logic [127:0] dtw_i4;
  logic [3:0]   req_v;
  logic [1:0]   sel;

  logic [1:0]  req2;
  logic [3:0]  reqf, reqr;
  logic [31:0] addr2, addrf, addrr, dout2, doutf, doutr, dtr2, dtrf, dtrr;
  logic        rw2, rwf, rwr, valid2, validf, validr, busy2, busyf, busyr;
  logic [1:0]  ack2;
  logic [3:0]  ackf, ackr;
  logic [0:0]  gid2;
  logic [1:0]  gidf, gidr;

  logic [31:0] o_addr, o_dout, o_dtr;
  logic        o_rw, o_valid, o_busy;
  logic [3:0]  o_ack;
  logic [1:0]  o_gid;

  typedef struct packed {
    logic [1:0]  ch;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } item_t;

  item_t sb[$];
  int n_cmp;
  int n_bad;

  assign req2 = (sel == 2'd0) ? req_v[1:0] : 2'b00;
  assign reqf = (sel == 2'd1) ? req_v : 4'b0000;
  assign reqr = (sel == 2'd2) ? req_v : 4'b0000;

  hs32_mem_arb #(.NCH(2), .AW(32), .DW(32), .RR(0)) dut2 (
    .clk(clk), .reset(reset), .addr(addr2), .rw(rw2), .dout(dout2), .din(din),
    .valid(valid2), .done(done), .req(req2), .rw_i(rw_i4[1:0]),
    .addr_i(addr_i4[63:0]), .dtw_i(dtw_i4[63:0]), .dtr(dtr2), .ack(ack2),
    .gnt_id(gid2), .busy(busy2));

  hs32_mem_arb #(.NCH(4), .AW(32), .DW(32), .RR(0)) dutf (
    .clk(clk), .reset(reset), .addr(addrf), .rw(rwf), .dout(doutf), .din(din),
    .valid(validf), .done(done), .req(reqf), .rw_i(rw_i4),
    .addr_i(addr_i4), .dtw_i(dtw_i4), .dtr(dtrf), .ack(ackf),
    .gnt_id(gidf), .busy(busyf));

  hs32_mem_arb #(.NCH(4), .AW(32), .DW(32), .RR(1)) dutr (
    .clk(clk), .reset(reset), .addr(addrr), .rw(rwr), .dout(doutr), .din(din),
    .valid(validr), .done(done), .req(reqr), .rw_i(rw_i4),
    .addr_i(addr_i4), .dtw_i(dtw_i4), .dtr(dtrr), .ack(ackr),
    .gnt_id(gidr), .busy(busyr));

  // Route the selected instance's outputs onto common observation names.
  always_comb begin
    case (sel)
      2'd0: begin
        o_addr = addr2; o_dout = dout2; o_dtr = dtr2; o_rw = rw2;
        o_valid = valid2; o_busy = busy2; o_ack = {2'b00, ack2}; o_gid = {1'b0, gid2};
      end
      2'd1: begin
        o_addr = addrf; o_dout = doutf; o_dtr = dtrf; o_rw = rwf;
        o_valid = validf; o_busy = busyf; o_ack = ackf; o_gid = gidf;
      end
      default: begin
        o_addr = addrr; o_dout = doutr; o_dtr = dtrr; o_rw = rwr;
        o_valid = validr; o_busy = busyr; o_ack = ackr; o_gid = gidr;
      end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program a channel's inputs and push the transaction it should produce.
  task automatic post(input int ch, input logic rw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd);
    item_t it;
    rw_i4[ch] = rw;
    addr_i4[ch*32 +: 32] = a;
    dtw_i4[ch*32 +: 32]  = wd;
    it.ch = 2'(ch); it.rw = rw; it.addr = a; it.wd = wd; it.rd = rd;
    sb.push_back(it);
  endtask

  // Act as the memory for the next expected transaction: wait for valid,
  // hold it for lat cycles (done on the last one), then check the ack cycle.
  task automatic serve(input int lat, input logic [3:0] raise, input bit keep);
    item_t it;
    int waited;
    it = sb.pop_front();
    waited = 0;
    while (o_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("valid_seen", 64'(o_valid), 64'(1'b1));
    chk("req_to_valid_cycles", 64'(waited), 64'(1));
    for (int i = 0; i < lat; i++) begin
      chk("gnt_id", 64'(o_gid), 64'(it.ch));
      chk("addr", 64'(o_addr), 64'(it.addr));
      chk("rw", 64'(o_rw), 64'(it.rw));
      if (it.rw) chk("dout", 64'(o_dout), 64'(it.wd));
      chk("valid_hold", 64'(o_valid), 64'(1'b1));
      chk("busy_gnt", 64'(o_busy), 64'(1'b1));
      chk("ack_in_gnt", 64'(o_ack), 64'(4'b0000));
      if (i == 1) req_v = req_v | raise;
      if (i == lat - 1) begin
        done = 1'b1;
        din  = it.rd;
      end
      step();
    end
    done = 1'b0;
    din  = 32'h0000_0000;
    chk("ack_onehot", 64'(o_ack), 64'(4'b0001 << it.ch));
    chk("dtr", 64'(o_dtr), 64'(it.rd));
    chk("valid_resp", 64'(o_valid), 64'(1'b0));
    chk("busy_resp", 64'(o_busy), 64'(1'b1));
    chk("gnt_id_resp", 64'(o_gid), 64'(it.ch));
    if (!keep) req_v[it.ch] = 1'b0;
    step();
    chk("ack_cleared", 64'(o_ack), 64'(4'b0000));
    chk("busy_idle", 64'(o_busy), 64'(1'b0));
    chk("dtr_hold", 64'(o_dtr), 64'(it.rd));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; done = 1'b0; din = 32'h0000_0000;
    rw_i4 = 4'b0000; addr_i4 = '0; dtw_i4 = '0; req_v = 4'b0000; sel = 2'd0;
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_valid", 64'(o_valid), 64'(1'b0));
      chk("rst_ack", 64'(o_ack), 64'(4'b0000));
      chk("rst_dtr", 64'(o_dtr), 64'(32'h0));
      chk("rst_gnt_id", 64'(o_gid), 64'(2'd0));
      chk("rst_busy", 64'(o_busy), 64'(1'b0));
    end
    reset = 1'b0;
    step();

    // Single read on NCH=2.
    sel = 2'd0;
    post(0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    req_v = 4'b0001;
    serve(2, 4'b0000, 1'b0);

    // Write on channel 1.
    post(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hA5A5_0001);
    req_v = 4'b0010;
    serve(2, 4'b0000, 1'b0);

    // Grant lock: channel 1 raises req while channel 0 holds the grant.
    post(0, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D);
    post(1, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF);
    req_v = 4'b0001;
    serve(5, 4'b0010, 1'b0);
    serve(2, 4'b0000, 1'b0);
    step();
    chk("idle_after_lock", 64'(o_valid), 64'(1'b0));

    // Fixed priority on NCH=4: req 1010 held, order 1 then 3.
    sel = 2'd1;
    post(1, 1'b0, 32'h0000_1111, 32'h0, 32'h1111_0001);
    post(3, 1'b1, 32'h0000_3333, 32'hC0DE_0003, 32'h3333_0003);
    req_v = 4'b1010;
    serve(1, 4'b0000, 1'b0);
    serve(3, 4'b0000, 1'b0);

    // Round-robin on NCH=4: all requesting continuously, order 0,1,2,3,0.
    sel = 2'd2;
    post(0, 1'b0, 32'h0000_A000, 32'h0, 32'hAAAA_0000);
    post(1, 1'b0, 32'h0000_A001, 32'h0, 32'hAAAA_0001);
    post(2, 1'b0, 32'h0000_A002, 32'h0, 32'hAAAA_0002);
    post(3, 1'b0, 32'h0000_A003, 32'h0, 32'hAAAA_0003);
    post(0, 1'b0, 32'h0000_A000, 32'h0, 32'hAAAA_0004);
    req_v = 4'b1111;
    for (int k = 0; k < 4; k++) serve(1, 4'b0000, 1'b1);
    serve(1, 4'b0000, 1'b0);
    req_v = 4'b0000;
    step();
    chk("rr_stopped", 64'(o_valid), 64'(1'b0));

    // Reset mid-GNT: pointer currently points at 0, so without a pointer
    // reinit a 0011 request would go to channel 1.
    req_v = 4'b0001;
    step();
    chk("pre_reset_valid", 64'(o_valid), 64'(1'b1));
    chk("pre_reset_gnt", 64'(o_gid), 64'(2'd0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_gnt_valid", 64'(o_valid), 64'(1'b0));
    chk("reset_gnt_ack", 64'(o_ack), 64'(4'b0000));
    chk("reset_gnt_busy", 64'(o_busy), 64'(1'b0));
    post(0, 1'b0, 32'h0000_B000, 32'h0, 32'hBBBB_0000);
    post(1, 1'b0, 32'h0000_B001, 32'h0, 32'hBBBB_0001);
    req_v = 4'b0011;
    serve(2, 4'b0000, 1'b0);
    serve(2, 4'b0000, 1'b0);
    step();
    chk("final_idle", 64'(o_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
